haar_ll_stream: RTL and testbench
=================================

HAAR_LL_STREAM -- requirements
Module: haar_ll_stream

Interface
REQ-001 Parameter IMG_W, default 8: image width in pixels; even, 2..1024.
REQ-002 Parameter IMG_H, default 8: image height in pixels; even, 2..1024.
REQ-003 Parameter COEF_W, default 32: LL coefficient width; matches the embedding stage's LL1/LL2 operand width.
REQ-004 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 Port rst_n, input, 1: synchronous, active-low reset.
REQ-006 Port start, input, 1: one-cycle pulse that begins a frame.
REQ-007 Port pix_in, input, 8: pixel value, row-major order.
REQ-008 Port pix_valid, input, 1: pix_in is valid.
REQ-009 Port pix_ready, output, 1: block accepts a pixel; a transfer occurs when pix_valid and pix_ready are both high.
REQ-010 Port ll_out, output, COEF_W: LL coefficient sent to the embedding stage.
REQ-011 Port ll_valid, output, 1: ll_out is valid.
REQ-012 Port ll_ready, input, 1: downstream accepts ll_out; a transfer occurs when ll_valid and ll_ready are both high.
REQ-013 Port busy, output, 1: high from the cycle after an accepted start until frame_done.
REQ-014 Port frame_done, output, 1: one-cycle pulse after the last LL of the frame is transferred.

Function
REQ-015 The block SHALL compute one unnormalized Haar LL value per 2x2 block: LL = p(2r,2c) + p(2r,2c+1) + p(2r+1,2c) + p(2r+1,2c+1). The result is 10 bits, zero-extended to COEF_W.
REQ-016 The block SHALL use the FSM states IDLE, RUN, FLUSH and DONE.
REQ-017 IDLE->RUN on start. RUN->FLUSH when the last pixel is accepted. FLUSH->DONE when no LL is pending. DONE->IDLE after one cycle.
REQ-018 start SHALL be ignored in any state other than IDLE.
REQ-019 The block SHALL keep a column counter (0..IMG_W-1) and a row counter (0..IMG_H-1).
REQ-020 Both counters SHALL advance only on a pixel transfer. The column counter wraps to 0 and the row counter increments at IMG_W-1.
REQ-021 The block SHALL hold the first pixel of each horizontal pair (even column) in a 8-bit pair register.
REQ-022 On even rows, at each odd column, the block SHALL write the pair sum (9 bits) into line-buffer entry col/2. The line buffer holds IMG_W/2 entries of 9 bits.
REQ-023 On odd rows, at each odd column, the block SHALL form pair sum + line-buffer entry col/2 and load it into the output register. ll_valid SHALL be high the next cycle, i.e. 1-cycle latency from the completing pixel transfer.
REQ-024 The output register SHALL be a single entry. ll_out and ll_valid SHALL stay stable while ll_valid is high and ll_ready is low.
REQ-025 pix_ready SHALL be (state==RUN) and not (ll_valid and not ll_ready). The block never drops or overwrites an LL.
REQ-026 If an output transfer and a new LL load occur in the same cycle, the new value SHALL replace the old one and ll_valid SHALL stay high.
REQ-027 Pixels presented in IDLE, FLUSH or DONE SHALL NOT be accepted (pix_ready low).
REQ-028 Each frame SHALL produce exactly (IMG_W/2)*(IMG_H/2) LL transfers before frame_done.

Reset
REQ-029 When rst_n is low at a clock edge, the block SHALL enter IDLE and clear the counters, pair register and output register.
REQ-030 Reset values: ll_out=0, ll_valid=0, pix_ready=0, busy=0, frame_done=0.
REQ-031 Line-buffer contents SHALL need no reset; every entry is written before it is read.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no further LL or frame_done output. A later start SHALL begin a clean frame.

Verification (IMG_W=4, IMG_H=4)
REQ-033 All pixels 255, ll_ready held high -> 4 LL transfers, each 1020, then one frame_done pulse.
REQ-034 Pixels 0..15 row-major -> LL sequence 10, 18, 42, 50.
REQ-035 Ramp stream with ll_ready low for 3 cycles after the first LL -> ll_out held at 10 and pix_ready low during the stall. Output sequence stays 10, 18, 42, 50.
REQ-036 rst_n low for 1 cycle after 6 pixels, then start and a constant-100 frame -> only four 400 values appear and no output from the aborted frame.
REQ-037 start pulsed again during RUN -> ignored; counters and outputs identical to an undisturbed frame; exactly one frame_done.
REQ-038 pix_valid toggled every other cycle with a ramp stream -> same LL sequence as REQ-034; no pixel accepted while pix_valid is low.

Source files
------------

// File: rtl/haar_ll_stream_if.sv
// Pixel-in / LL-out stream bundle for the Haar LL stage.
// master drives pixels and LL back-pressure; slave is the transform block.
interface haar_ll_stream_if #(
    parameter int COEF_W = 32
);
    logic [7:0]        pix_in;
    logic              pix_valid;
    logic              pix_ready;
    logic [COEF_W-1:0] ll_out;
    logic              ll_valid;
    logic              ll_ready;

    modport master (
        output pix_in, pix_valid, ll_ready,
        input  pix_ready, ll_out, ll_valid
    );

    modport slave (
        input  pix_in, pix_valid, ll_ready,
        output pix_ready, ll_out, ll_valid
    );
endinterface

// File: rtl/haar_ll_stream.sv
// Streaming unnormalized Haar LL: sums each 2x2 block of a row-major frame.
// One line buffer of horizontal pair sums; single-entry output register.
module haar_ll_stream #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int COEF_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    haar_ll_stream_if.slave  s,
    output logic             busy,
    output logic             frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int LW = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;
    localparam int LN = IMG_W / 2;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [7:0]        pair_q, pair_d;
    logic [COEF_W-1:0] ll_q, ll_d;
    logic              llv_q, llv_d;
    logic [8:0]        lb_q [LN];

    logic          pix_xfer;
    logic          col_last;
    logic          row_last;
    logic          lb_we;
    logic [LW-1:0] lb_idx;
    logic [8:0]    psum;
    logic [9:0]    llsum;

    assign s.pix_ready = (state_q == RUN) && !(llv_q && !s.ll_ready);
    assign s.ll_out    = ll_q;
    assign s.ll_valid  = llv_q;
    assign busy        = (state_q == RUN) || (state_q == FLUSH);
    assign frame_done  = (state_q == DONE);

    assign pix_xfer = s.pix_valid && s.pix_ready;
    assign col_last = (col_q == CW'(IMG_W - 1));
    assign row_last = (row_q == RW'(IMG_H - 1));
    assign lb_idx   = LW'(col_q >> 1);
    assign psum     = {1'b0, pair_q} + {1'b0, s.pix_in};
    assign llsum    = {1'b0, psum} + {1'b0, lb_q[lb_idx]};

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        pair_d  = pair_q;
        ll_d    = ll_q;
        llv_d   = llv_q;
        lb_we   = 1'b0;

        if (llv_q && s.ll_ready) llv_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            RUN: begin
                if (pix_xfer && col_last && row_last) state_d = FLUSH;
            end
            FLUSH: begin
                if (!llv_q || s.ll_ready) state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (pix_xfer) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            // Even column opens a pair; odd column closes it.
            if (!col_q[0]) begin
                pair_d = s.pix_in;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                ll_d  = COEF_W'(llsum);
                llv_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            pair_q  <= '0;
            ll_q    <= '0;
            llv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pair_q  <= pair_d;
            ll_q    <= ll_d;
            llv_q   <= llv_d;
        end
    end

    // Every entry is written on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (lb_we) lb_q[lb_idx] <= psum;
    end
endmodule

// File: tb/tb_haar_ll_stream.sv
// Randomized self-checking bench for haar_ll_stream on a 4x4 frame.
// Expected LL values come from direct 2x2 block sums of the pixel array.
module tb_haar_ll_stream;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int N  = W * H;
    localparam int CO = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic frame_done;

    haar_ll_stream_if #(.COEF_W(CO)) bus ();

    haar_ll_stream #(
        .IMG_W (W),
        .IMG_H (H),
        .COEF_W(CO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .s         (bus),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;
    int pix [N];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // vm: 0 valid always, 1 toggling, 2 random
    // rm: 0 ready always, 1 stall 3 cycles on first LL, 2 random
    task automatic run_frame(input int vm, input int rm, input bit restart,
                             input string tag);
        int exp[$];
        int idx   = 0;
        int got   = 0;
        int done  = 0;
        int cyc   = 0;
        int stall = 0;
        int post  = 0;
        bit hold  = 0;
        bit v;
        bit r;
        logic [31:0] hv = '0;
        for (int br = 0; br < H / 2; br++)
            for (int bc = 0; bc < W / 2; bc++)
                exp.push_back(pix[2*br*W + 2*bc] + pix[2*br*W + 2*bc + 1]
                            + pix[(2*br+1)*W + 2*bc]
                            + pix[(2*br+1)*W + 2*bc + 1]);
        while (cyc < 2000 && (done == 0 || post < 4)) begin
            @(negedge clk);
            start = (cyc == 0) || (restart && cyc == 6);
            case (vm)
                0:       v = 1'b1;
                1:       v = cyc[0];
                default: v = 1'($urandom % 2);
            endcase
            bus.pix_valid = (idx < N) && v;
            if (idx < N) bus.pix_in = 8'(pix[idx]);
            else         bus.pix_in = 8'h00;
            r = (rm == 2) ? 1'($urandom % 2) : 1'b1;
            if (rm == 1 && bus.ll_valid && stall < 3) begin
                r = 1'b0;
                stall++;
            end
            bus.ll_ready = r;
            #1;
            if (hold) begin
                chk({tag, " hold_valid"}, 32'(bus.ll_valid), 1);
                chk({tag, " hold_data"}, bus.ll_out, hv);
            end
            if (rm == 1 && !r) begin
                chk({tag, " stall_data"}, bus.ll_out, exp[0]);
                chk({tag, " stall_pix_ready"}, 32'(bus.pix_ready), 0);
            end
            hold = bus.ll_valid && !bus.ll_ready;
            hv   = bus.ll_out;
            if (bus.ll_valid && bus.ll_ready) begin
                if (got < exp.size())
                    chk($sformatf("%s ll[%0d]", tag, got), bus.ll_out, exp[got]);
                else
                    chk({tag, " extra_ll"}, got + 1, exp.size());
                got++;
            end
            if (bus.pix_valid && bus.pix_ready) idx++;
            if (frame_done) done++;
            if (done > 0) post++;
            if (cyc == 3) chk({tag, " busy"}, 32'(busy), 1);
            cyc++;
        end
        start = 1'b0;
        bus.pix_valid = 1'b0;
        bus.ll_ready = 1'b1;
        chk({tag, " ll_count"}, got, exp.size());
        chk({tag, " frame_done_count"}, done, 1);
        chk({tag, " pix_count"}, idx, N);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, " ll_out"}, bus.ll_out, 0);
        chk({tag, " ll_valid"}, 32'(bus.ll_valid), 0);
        chk({tag, " pix_ready"}, 32'(bus.pix_ready), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " frame_done"}, 32'(frame_done), 0);
    endtask

    initial begin
        int acc;
        int n;
        bit leak;
        bus.pix_in    = 8'h00;
        bus.pix_valid = 1'b1;
        bus.ll_ready  = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("idle_pix_ready", 32'(bus.pix_ready), 0);
        bus.pix_valid = 1'b0;

        foreach (pix[i]) pix[i] = 255;
        run_frame(0, 0, 1'b0, "all255");

        foreach (pix[i]) pix[i] = i;
        run_frame(0, 0, 1'b0, "ramp");
        run_frame(0, 1, 1'b0, "stall");
        run_frame(0, 0, 1'b1, "restart");
        run_frame(1, 0, 1'b0, "toggle");

        // Abort a frame after six pixels with an LL still pending.
        @(negedge clk);
        start = 1'b1;
        bus.ll_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        acc = 0;
        n = 0;
        while (acc < 6 && n < 50) begin
            bus.pix_valid = 1'b1;
            bus.pix_in = 8'd77;
            #1;
            if (bus.pix_valid && bus.pix_ready) acc++;
            @(negedge clk);
            n++;
        end
        bus.pix_valid = 1'b0;
        chk("abort_accepted", acc, 6);
        chk("abort_pending", 32'(bus.ll_valid), 1);
        rst_n = 1'b0;
        bus.ll_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_reset_outs("abort_reset");
        leak = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (bus.ll_valid || frame_done) leak = 1'b1;
        end
        chk("abort_no_output", 32'(leak), 0);
        foreach (pix[i]) pix[i] = 100;
        run_frame(0, 0, 1'b0, "after_abort");

        for (int k = 0; k < 4; k++) begin
            foreach (pix[i]) pix[i] = $urandom_range(0, 255);
            run_frame(2, 2, 1'b0, $sformatf("rand%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
